// File: rtl/jk_seq_pkg.sv
// Shared encodings for the JK bank sequencer: operation codes and controller states.
package jk_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_SET    = 3'd1,
    OP_CLR    = 3'd2,
    OP_LOAD   = 3'd3,
    OP_TOGGLE = 3'd4,
    OP_COUNT  = 3'd5,
    OP_SHIFT  = 3'd6,
    OP_RSVD   = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/jk_bank_sequencer_if.sv
// Command handshake bundle between a command source and the JK bank sequencer.
interface jk_bank_sequencer_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_len;

  modport master (output cmd_valid, cmd_op, cmd_data, cmd_len, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, cmd_len, output cmd_ready);
endinterface

// File: rtl/jk_bank.sv
// Bank of WIDTH JK flip-flops with asynchronous active-low clear.
module jk_bank #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        case ({j[i], k[i]})
          2'b10:   q[i] <= 1'b1;
          2'b01:   q[i] <= 1'b0;
          2'b11:   q[i] <= ~q[i];
          default: q[i] <= q[i];
        endcase
      end
    end
  end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Command-driven controller that sequences j/k drive for a JK flip-flop bank.
module jk_bank_sequencer
  import jk_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  jk_bank_sequencer_if.slave  cmd,
  output logic [WIDTH-1:0]    q,
  output logic                busy,
  output logic                done
);

  state_t           state, state_nxt;
  op_t              op_r;
  logic [WIDTH-1:0] data_r;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] steps_in;
  logic             ready_r;
  logic             accept;
  logic             carry;
  logic [WIDTH-1:0] j, k;

  assign cmd.cmd_ready = ready_r;
  assign accept        = cmd.cmd_valid && ready_r;

  always_comb begin
    steps_in = '0;
    case (op_t'(cmd.cmd_op))
      OP_SET, OP_CLR, OP_LOAD, OP_TOGGLE: steps_in = CNT_W'(1);
      OP_COUNT, OP_SHIFT:                 steps_in = cmd.cmd_len;
      default:                            steps_in = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = (steps_in == '0) ? ST_DONE : ST_EXEC;
      ST_EXEC: if (cnt == CNT_W'(1)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ready/busy/done are all registered copies of state, so ready stays low
  // through the cycle in which done is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      op_r    <= OP_NOP;
      data_r  <= '0;
      cnt     <= '0;
      ready_r <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_r <= (state == ST_IDLE) && !accept;
      busy    <= (state != ST_IDLE);
      done    <= (state == ST_DONE);
      if (accept) begin
        op_r   <= op_t'(cmd.cmd_op);
        data_r <= cmd.cmd_data;
        cnt    <= steps_in;
      end else if (state == ST_EXEC) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    j     = '0;
    k     = '0;
    carry = 1'b1;
    if (state == ST_EXEC) begin
      case (op_r)
        OP_SET:    j = '1;
        OP_CLR:    k = '1;
        OP_LOAD: begin
          j = data_r;
          k = ~data_r;
        end
        OP_TOGGLE: begin
          j = data_r;
          k = data_r;
        end
        OP_COUNT: begin
          for (int unsigned i = 0; i < WIDTH; i++) begin
            j[i]  = carry;
            k[i]  = carry;
            carry = carry & q[i];
          end
        end
        OP_SHIFT: begin
          j = {q[WIDTH-2:0], data_r[0]};
          k = ~{q[WIDTH-2:0], data_r[0]};
        end
        default: ;
      endcase
    end
  end

  jk_bank #(.WIDTH(WIDTH)) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .j     (j),
    .k     (k),
    .q     (q)
  );

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed plus randomized bench for jk_bank_sequencer against an arithmetic bank model.
module tb_jk_bank_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] q;
  logic       busy, done;

  int compared = 0;
  int mismatched = 0;
  logic [3:0] q_m = '0;

  jk_bank_sequencer_if #(.WIDTH(4), .CNT_W(8)) bus ();

  jk_bank_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   (bus),
    .q     (q),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int n_steps(input logic [2:0] op, input logic [7:0] len);
    if (op >= 3'd1 && op <= 3'd4) return 1;
    if (op == 3'd5 || op == 3'd6) return int'(len);
    return 0;
  endfunction

  function automatic logic [3:0] model_step(input logic [2:0] op, input logic [3:0] d,
                                            input logic [3:0] cur);
    case (op)
      3'd1:    return 4'hF;
      3'd2:    return 4'h0;
      3'd3:    return d;
      3'd4:    return cur ^ d;
      3'd5:    return 4'((int'(cur) + 1) % 16);
      3'd6:    return 4'((int'(cur) * 2 + int'(d[0])) % 16);
      default: return cur;
    endcase
  endfunction

  task automatic run_cmd(input logic [2:0] op, input logic [3:0] data, input logic [7:0] len,
                         input bit early, input logic [2:0] e_op, input logic [3:0] e_data,
                         input logic [7:0] e_len);
    int n, busy_cnt, done_cnt, waited;
    @(negedge clk);
    waited = 0;
    while (!bus.cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_before_cmd", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_len   = len;
    @(posedge clk); #1;
    // inputs scrambled after acceptance must be ignored
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'($urandom_range(0, 7));
    bus.cmd_data  = 4'($urandom_range(0, 15));
    bus.cmd_len   = 8'($urandom_range(0, 255));
    n = n_steps(op, len);
    busy_cnt = 0;
    done_cnt = 0;
    for (int s = 1; s <= n; s++) begin
      @(posedge clk); #1;
      q_m = model_step(op, data, q_m);
      chk("q_step", q, q_m);
      chk("ready_in_exec", bus.cmd_ready, 0);
      busy_cnt += int'(busy);
      done_cnt += int'(done);
    end
    @(posedge clk); #1;
    chk("q_at_done", q, q_m);
    chk("done_pulse", done, 1);
    chk("ready_during_done", bus.cmd_ready, 0);
    busy_cnt += int'(busy);
    done_cnt += int'(done);
    if (early) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = e_op;
      bus.cmd_data  = e_data;
      bus.cmd_len   = e_len;
    end
    @(posedge clk); #1;
    chk("done_cleared", done, 0);
    chk("ready_back", bus.cmd_ready, 1);
    chk("busy_cleared", busy, 0);
    chk("q_hold_after", q, q_m);
    chk("busy_cycles", 32'(busy_cnt), 32'(n + 1));
    chk("done_count", 32'(done_cnt), 1);
  endtask

  initial begin
    int dn;
    logic [2:0] rop;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_data  = '0;
    bus.cmd_len   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_q", q, 0);
    chk("reset_ready", bus.cmd_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_cmd(3'd3, 4'b1010, 8'd0, 0, 3'd0, 4'd0, 8'd0);
    chk("load_1010", q, 4'b1010);
    run_cmd(3'd4, 4'b0110, 8'd0, 0, 3'd0, 4'd0, 8'd0);
    chk("toggle_0110", q, 4'b1100);
    run_cmd(3'd1, 4'd0, 8'd0, 0, 3'd0, 4'd0, 8'd0);
    chk("set_all", q, 4'b1111);
    run_cmd(3'd2, 4'd0, 8'd0, 0, 3'd0, 4'd0, 8'd0);
    chk("clr_all", q, 4'b0000);
    run_cmd(3'd5, 4'd0, 8'd18, 0, 3'd0, 4'd0, 8'd0);
    chk("count18_final", q, 4'b0010);
    run_cmd(3'd3, 4'b0001, 8'd0, 0, 3'd0, 4'd0, 8'd0);
    run_cmd(3'd6, 4'b0001, 8'd3, 0, 3'd0, 4'd0, 8'd0);
    chk("shift3_final", q, 4'b1111);
    run_cmd(3'd2, 4'd0, 8'd0, 0, 3'd0, 4'd0, 8'd0);
    run_cmd(3'd5, 4'd0, 8'd0, 0, 3'd0, 4'd0, 8'd0);
    chk("count0_unchanged", q, 4'b0000);
    // valid raised during DONE must wait for IDLE
    run_cmd(3'd7, 4'hF, 8'd9, 1, 3'd3, 4'b0110, 8'd0);
    chk("op7_unchanged", q, 4'b0000);
    run_cmd(3'd3, 4'b0110, 8'd0, 0, 3'd0, 4'd0, 8'd0);
    chk("early_cmd_load", q, 4'b0110);
    run_cmd(3'd2, 4'd0, 8'd0, 0, 3'd0, 4'd0, 8'd0);

    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd5;
    bus.cmd_data  = 4'd0;
    bus.cmd_len   = 8'd10;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      q_m = model_step(3'd5, 4'd0, q_m);
    end
    chk("abort_pre_q", q, 4'd5);
    rst_n = 1'b0;
    #1;
    q_m = '0;
    chk("abort_q", q, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", bus.cmd_ready, 1);
    chk("abort_done", done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (12) begin
      @(posedge clk); #1;
      dn += int'(done);
    end
    chk("abort_no_done", 32'(dn), 0);
    run_cmd(3'd3, 4'b0101, 8'd0, 0, 3'd0, 4'd0, 8'd0);
    chk("post_abort_load", q, 4'b0101);

    for (int r = 0; r < 25; r++) begin
      rop = 3'($urandom_range(0, 7));
      run_cmd(rop, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 20)),
              0, 3'd0, 4'd0, 8'd0);
    end
    run_cmd(3'd5, 4'd0, 8'd255, 0, 3'd0, 4'd0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
